dct_quant_zigzag: RTL and testbench



---
 rtl/dct_quant_pkg.sv | 54 +++++
 rtl/dct_quant_zigzag_quant_mul.sv | 35 +++
 rtl/dct_quant_zigzag.sv | 156 +++++++++++++++
 tb/tb_dct_quant_zigzag.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/dct_quant_pkg.sv
// Shared constants for the DCT quantize/zigzag stage: widths, FSM states,
// zigzag order, JPEG luminance table and its 16-bit reciprocals.
package dct_quant_pkg;

  localparam int COEF_W      = 32;
  localparam int OUT_W       = 12;
  localparam int RECIP_SHIFT = 16;
  localparam int RECIP_W     = 16;
  localparam int NUM_COEF    = 64;
  localparam int IDX_W       = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } state_t;

  // Entry k holds {r[2:0], c[2:0]} of the k-th coefficient in zigzag order.
  localparam logic [5:0] ZIGZAG [NUM_COEF] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

  localparam logic [7:0] QUANT_TBL [NUM_COEF] = '{
    16, 11, 10, 16,  24,  40,  51,  61,
    12, 12, 14, 19,  26,  58,  60,  55,
    14, 13, 16, 24,  40,  57,  69,  56,
    14, 17, 22, 29,  51,  87,  80,  62,
    18, 22, 37, 56,  68, 109, 103,  77,
    24, 35, 55, 64,  81, 104, 113,  92,
    49, 64, 78, 87, 103, 121, 120, 101,
    72, 92, 95, 98, 112, 100, 103,  99
  };

  // round(65536 / QUANT_TBL[i]), row-major like QUANT_TBL.
  localparam logic [RECIP_W-1:0] RECIP_TBL [NUM_COEF] = '{
    4096, 5958, 6554, 4096, 2731, 1638, 1285, 1074,
    5461, 5461, 4681, 3449, 2521, 1130, 1092, 1192,
    4681, 5041, 4096, 2731, 1638, 1150,  950, 1170,
    4681, 3855, 2979, 2260, 1285,  753,  819, 1057,
    3641, 2979, 1771, 1170,  964,  601,  636,  851,
    2731, 1872, 1192, 1024,  809,  630,  580,  712,
    1337, 1024,  840,  753,  636,  542,  546,  649,
     910,  712,  690,  669,  585,  655,  636,  662
  };

endpackage

// File: rtl/dct_quant_zigzag_quant_mul.sv
// Combinational quantizer: |x| * reciprocal, round half away from zero,
// saturate magnitude to 2047 and restore the sign.
module quant_mul
  import dct_quant_pkg::*;
(
  input  logic signed [COEF_W-1:0]  x,
  input  logic        [RECIP_W-1:0] recip,
  output logic signed [OUT_W-1:0]   q
);

  localparam int MAG_W  = COEF_W + 1;
  localparam int PROD_W = MAG_W + RECIP_W + 1;
  localparam logic [OUT_W-2:0] MAX_MAG = '1;

  logic              neg;
  logic [MAG_W-1:0]  x_ext;
  logic [MAG_W-1:0]  mag;
  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] shifted;
  logic [OUT_W-2:0]  p_sat;
  logic [OUT_W-1:0]  pos;

  // The 33-bit magnitude keeps -2^31 representable after negation.
  always_comb begin
    neg     = x[COEF_W-1];
    x_ext   = {x[COEF_W-1], x};
    mag     = neg ? (~x_ext + MAG_W'(1)) : x_ext;
    prod    = PROD_W'(mag) * PROD_W'(recip) + (PROD_W'(1) << (RECIP_SHIFT - 1));
    shifted = prod >> RECIP_SHIFT;
    p_sat   = (|shifted[PROD_W-1:OUT_W-1]) ? MAX_MAG : shifted[OUT_W-2:0];
    pos     = {1'b0, p_sat};
    q       = neg ? -pos : pos;
  end

endmodule

// File: rtl/dct_quant_zigzag.sv
// Captures an 8x8 DCT block on the upstream Done level, then streams the
// quantized coefficients in zigzag order over a valid/ready handshake.
module dct_quant_zigzag
  import dct_quant_pkg::*;
(
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [8*COEF_W-1:0]        dct_0,
  input  logic [8*COEF_W-1:0]        dct_1,
  input  logic [8*COEF_W-1:0]        dct_2,
  input  logic [8*COEF_W-1:0]        dct_3,
  input  logic [8*COEF_W-1:0]        dct_4,
  input  logic [8*COEF_W-1:0]        dct_5,
  input  logic [8*COEF_W-1:0]        dct_6,
  input  logic [8*COEF_W-1:0]        dct_7,
  input  logic                       dct_valid,
  output logic signed [OUT_W-1:0]    coef_out,
  output logic [IDX_W-1:0]           coef_idx,
  output logic                       coef_valid,
  input  logic                       coef_ready,
  output logic                       coef_last,
  output logic                       busy,
  output logic                       Done
);

  state_t state_q, state_d;

  logic [COEF_W-1:0]       blk_q [NUM_COEF];
  logic [COEF_W-1:0]       blk_d [NUM_COEF];
  logic [8*COEF_W-1:0]     rows  [8];
  logic                    armed_q, armed_d;
  logic signed [OUT_W-1:0] coef_out_q, coef_out_d;
  logic [IDX_W-1:0]        coef_idx_q, coef_idx_d;
  logic                    coef_valid_q, coef_valid_d;
  logic                    coef_last_q, coef_last_d;

  logic                    capture;
  logic                    accept;
  logic [IDX_W-1:0]        next_idx;
  logic [IDX_W-1:0]        sel_idx;
  logic [5:0]              zz_pos;
  logic [COEF_W-1:0]       x_sel;
  logic [RECIP_W-1:0]      recip_sel;
  logic signed [OUT_W-1:0] quant_val;

  always_comb begin
    rows[0] = dct_0;
    rows[1] = dct_1;
    rows[2] = dct_2;
    rows[3] = dct_3;
    rows[4] = dct_4;
    rows[5] = dct_5;
    rows[6] = dct_6;
    rows[7] = dct_7;
  end

  assign capture  = (state_q == ST_IDLE) && dct_valid && armed_q;
  assign accept   = coef_valid_q && coef_ready;
  assign next_idx = coef_idx_q + IDX_W'(1);

  // LOAD fetches zigzag entry 0; RUN always prefetches the entry after the one on the bus.
  assign sel_idx   = (state_q == ST_LOAD) ? '0 : next_idx;
  assign zz_pos    = ZIGZAG[sel_idx];
  assign x_sel     = blk_q[zz_pos];
  assign recip_sel = RECIP_TBL[zz_pos];

  quant_mul u_quant_mul (
    .x     (x_sel),
    .recip (recip_sel),
    .q     (quant_val)
  );

  always_comb begin
    blk_d = blk_q;
    if (capture) begin
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) begin
          blk_d[r*8 + c] = rows[r][c*COEF_W +: COEF_W];
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    blk_q <= blk_d;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      armed_q      <= 1'b1;
      coef_out_q   <= '0;
      coef_idx_q   <= '0;
      coef_valid_q <= 1'b0;
      coef_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      coef_out_q   <= coef_out_d;
      coef_idx_q   <= coef_idx_d;
      coef_valid_q <= coef_valid_d;
      coef_last_q  <= coef_last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (capture) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_RUN;
      ST_RUN:  if (accept && (coef_idx_q == IDX_W'(NUM_COEF - 1))) state_d = ST_DONE;
      ST_DONE: if (!dct_valid) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Holding dct_valid high never re-arms, so one Done level yields one block.
  always_comb begin
    armed_d      = armed_q;
    coef_out_d   = coef_out_q;
    coef_idx_d   = coef_idx_q;
    coef_valid_d = coef_valid_q;
    coef_last_d  = coef_last_q;
    if (capture)    armed_d = 1'b0;
    if (!dct_valid) armed_d = 1'b1;
    case (state_q)
      ST_LOAD: begin
        coef_out_d   = quant_val;
        coef_idx_d   = '0;
        coef_valid_d = 1'b1;
        coef_last_d  = 1'b0;
      end
      ST_RUN: begin
        if (accept) begin
          if (coef_idx_q == IDX_W'(NUM_COEF - 1)) begin
            coef_valid_d = 1'b0;
            coef_last_d  = 1'b0;
          end else begin
            coef_out_d  = quant_val;
            coef_idx_d  = next_idx;
            coef_last_d = (next_idx == IDX_W'(NUM_COEF - 1));
          end
        end
      end
      default: ;
    endcase
  end

  assign coef_out   = coef_out_q;
  assign coef_idx   = coef_idx_q;
  assign coef_valid = coef_valid_q;
  assign coef_last  = coef_last_q;
  assign busy       = (state_q == ST_LOAD) || (state_q == ST_RUN);
  assign Done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_dct_quant_zigzag.sv
// Directed bench for dct_quant_zigzag: hand-computed quantized values,
// zigzag ramp, saturation, backpressure, rearm and mid-stream reset.
module tb_dct_quant_zigzag;
  import dct_quant_pkg::*;

  logic              Clk;
  logic              Reset;
  logic [255:0]      dct_rows [8];
  logic              dct_valid;
  logic signed [11:0] coef_out;
  logic [5:0]        coef_idx;
  logic              coef_valid;
  logic              coef_ready;
  logic              coef_last;
  logic              busy;
  logic              Done;

  logic [31:0] blk [64];
  int          expected_q [64];
  int          error_count;
  int          check_count;

  // Independent copy of the JPEG zigzag order as r*8+c.
  int zz_tb [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  dct_quant_zigzag dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .dct_0      (dct_rows[0]),
    .dct_1      (dct_rows[1]),
    .dct_2      (dct_rows[2]),
    .dct_3      (dct_rows[3]),
    .dct_4      (dct_rows[4]),
    .dct_5      (dct_rows[5]),
    .dct_6      (dct_rows[6]),
    .dct_7      (dct_rows[7]),
    .dct_valid  (dct_valid),
    .coef_out   (coef_out),
    .coef_idx   (coef_idx),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .coef_last  (coef_last),
    .busy       (busy),
    .Done       (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    check_count++;
    if (actual != expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic clearBlock();
    for (int i = 0; i < 64; i++) begin
      blk[i]        = 32'd0;
      expected_q[i] = 0;
    end
  endtask

  task automatic applyStimulus();
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        dct_rows[r][c*32 +: 32] = blk[r*8 + c];
      end
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Raises dct_valid and follows one block through; first valid is sampled at the second edge after capture.
  task automatic runStream(input int stall_at, input int stall_len, input int abort_at);
    dct_valid  = 1'b1;
    coef_ready = 1'b1;
    tick();
    checkOutput("load_busy", int'(busy), 1);
    checkOutput("load_valid", int'(coef_valid), 0);
    for (int r = 0; r < 8; r++) dct_rows[r] = {8{32'h1234_5678}};
    tick();
    for (int n = 0; n < 64; n++) begin
      checkOutput($sformatf("valid[%0d]", n), int'(coef_valid), 1);
      checkOutput($sformatf("idx[%0d]", n), int'(coef_idx), n);
      checkOutput($sformatf("out[%0d]", n), int'(coef_out), expected_q[n]);
      checkOutput($sformatf("last[%0d]", n), int'(coef_last), (n == 63) ? 1 : 0);
      if (n == abort_at) return;
      if (n == stall_at) begin
        coef_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          checkOutput($sformatf("stall_valid[%0d]", s), int'(coef_valid), 1);
          checkOutput($sformatf("stall_idx[%0d]", s), int'(coef_idx), n);
          checkOutput($sformatf("stall_out[%0d]", s), int'(coef_out), expected_q[n]);
        end
        coef_ready = 1'b1;
      end
      tick();
    end
    checkOutput("end_valid", int'(coef_valid), 0);
    checkOutput("end_done", int'(Done), 1);
    checkOutput("end_busy", int'(busy), 0);
  endtask

  task automatic endBlock();
    dct_valid = 1'b0;
    tick();
    checkOutput("idle_done", int'(Done), 0);
    checkOutput("idle_busy", int'(busy), 0);
  endtask

  initial begin
    error_count = 0;
    check_count = 0;
    Reset       = 1'b1;
    dct_valid   = 1'b0;
    coef_ready  = 1'b1;
    clearBlock();
    applyStimulus();
    tick();
    tick();
    checkOutput("rst_valid", int'(coef_valid), 0);
    checkOutput("rst_idx", int'(coef_idx), 0);
    checkOutput("rst_out", int'(coef_out), 0);
    checkOutput("rst_last", int'(coef_last), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(Done), 0);
    Reset = 1'b0;
    tick();

    $display("[TB] DC only");
    clearBlock();
    blk[0] = 32'd1024;
    expected_q[0] = 64;
    applyStimulus();
    runStream(-1, 0, -1);
    endBlock();

    $display("[TB] rounding and sign");
    clearBlock();
    blk[0]  = -32'sd1000; expected_q[0]  = -63;
    blk[8]  = 32'd120;    expected_q[2]  = 10;
    blk[1]  = -32'sd5;    expected_q[1]  = 0;
    blk[2]  = -32'sd15;   expected_q[5]  = -2;
    blk[63] = 32'd1000;   expected_q[63] = 10;
    applyStimulus();
    runStream(-1, 0, -1);
    endBlock();

    $display("[TB] saturation");
    clearBlock();
    blk[0] = 32'h7FFF_FFFF; expected_q[0] = 2047;
    blk[1] = 32'h8000_0000; expected_q[1] = -2047;
    blk[9] = 32'h8000_0000; expected_q[4] = -2047;
    applyStimulus();
    runStream(-1, 0, -1);
    endBlock();

    // k*Q at zigzag slot k quantizes exactly to k; odd slots negated.
    $display("[TB] zigzag ramp with backpressure at idx 5");
    clearBlock();
    for (int k = 0; k < 64; k++) begin
      int v;
      v = k * int'(QUANT_TBL[zz_tb[k]]);
      blk[zz_tb[k]] = (k % 2 == 1) ? -v : v;
      expected_q[k] = (k % 2 == 1) ? -k : k;
    end
    applyStimulus();
    runStream(5, 3, -1);

    $display("[TB] rearm");
    repeat (4) tick();
    checkOutput("hold_done", int'(Done), 1);
    checkOutput("hold_valid", int'(coef_valid), 0);
    checkOutput("hold_busy", int'(busy), 0);
    clearBlock();
    blk[0] = 32'd160;  expected_q[0] = 10;
    blk[8] = -32'sd24; expected_q[2] = -2;
    applyStimulus();
    endBlock();
    runStream(-1, 0, -1);
    endBlock();

    $display("[TB] reset mid-stream");
    clearBlock();
    blk[0] = 32'd1024; expected_q[0] = 64;
    applyStimulus();
    runStream(-1, 0, 30);
    dct_valid = 1'b0;
    Reset     = 1'b1;
    #1;
    checkOutput("mid_rst_valid", int'(coef_valid), 0);
    checkOutput("mid_rst_busy", int'(busy), 0);
    checkOutput("mid_rst_done", int'(Done), 0);
    tick();
    checkOutput("mid_rst_valid_edge", int'(coef_valid), 0);
    checkOutput("mid_rst_idx", int'(coef_idx), 0);
    Reset = 1'b0;
    tick();
    clearBlock();
    blk[0] = -32'sd1000; expected_q[0] = -63;
    applyStimulus();
    runStream(-1, 0, -1);
    endBlock();

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
